raisin64_ifetch_queue: RTL and testbench

//   Instruction fetch stage that sits directly downstream of the instruction memory (imem) and upstream of decode.

---
 rtl/raisin64_ifetch_queue.sv | 158 +++++++++++++++
 tb/tb_raisin64_ifetch_queue.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/raisin64_ifetch_queue.sv
// Sequential instruction fetch feeding a DEPTH-entry {pc, instr} queue, with jump redirect/flush.
// Optional feature macro IFQ_STATS_EN adds saturating stall and flush counters.
module raisin64_ifetch_queue #(
    parameter logic [63:0] RESET_PC = 64'h0,
    parameter int          IMEM_AW  = 16,
    parameter int          DEPTH    = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    output logic               imem_en,
    output logic [IMEM_AW-1:0] imem_addr,
    input  logic [63:0]        imem_data,
    input  logic               jump_valid,
    input  logic [63:0]        jump_pc,
    output logic               out_valid,
    output logic [63:0]        out_instr,
    output logic [63:0]        out_pc,
    input  logic               out_ready
`ifdef IFQ_STATS_EN
    ,
    output logic [31:0]        stat_stall,
    output logic [15:0]        stat_flush
`endif
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic {IDLE, RUN} state_e;

    state_e        state_q, state_d;
    logic          rel_q, rel_d;
    logic [63:0]   fetch_pc_q, fetch_pc_d;
    logic          inflight_q, inflight_d;
    logic [63:0]   inflight_pc_q, inflight_pc_d;
    logic [PW-1:0] head_q, head_d;
    logic [PW-1:0] tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;

    logic [63:0]   q_pc    [DEPTH];
    logic [63:0]   q_instr [DEPTH];

    logic          q_nonempty;
    logic          pop;
    logic          deq;
    logic          wr_en;
    logic [CW:0]   need;
    logic [CW:0]   room;

    assign imem_addr = fetch_pc_q[IMEM_AW+2:3];

    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path can infer a latch.
        q_nonempty = (count_q != '0);
        out_valid  = q_nonempty || inflight_q;
        out_pc     = '0;
        out_instr  = '0;
        if (q_nonempty) begin
            out_pc    = q_pc[head_q];
            out_instr = q_instr[head_q];
        end else if (inflight_q) begin
            // Empty queue: the returning read is presented directly, so a redirect reaches decode in two cycles.
            out_pc    = inflight_pc_q;
            out_instr = imem_data;
        end

        pop   = out_valid && out_ready;
        deq   = pop && q_nonempty;
        wr_en = inflight_q && !jump_valid && !(pop && !q_nonempty);

        // Reserve a slot for the new read: occupancy after this cycle plus one must fit.
        need    = (CW+1)'(count_q) + (CW+1)'(inflight_q) + (CW+1)'(1);
        room    = (CW+1)'(DEPTH) + (CW+1)'(pop);
        imem_en = (state_q == RUN) && !jump_valid && (need <= room);

        rel_d   = 1'b1;
        state_d = state_q;
        if (state_q == IDLE && rel_q) begin
            state_d = RUN;
        end

        fetch_pc_d    = imem_en ? fetch_pc_q + 64'd8 : fetch_pc_q;
        inflight_d    = imem_en;
        inflight_pc_d = imem_en ? fetch_pc_q : inflight_pc_q;
        head_d        = deq   ? head_q + 1'b1 : head_q;
        tail_d        = wr_en ? tail_q + 1'b1 : tail_q;
        count_d       = count_q + CW'(wr_en) - CW'(deq);

        if (jump_valid) begin
            fetch_pc_d = jump_pc & ~64'h7;
            head_d     = '0;
            tail_d     = '0;
            count_d    = '0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            rel_q         <= 1'b0;
            fetch_pc_q    <= RESET_PC & ~64'h7;
            inflight_q    <= 1'b0;
            inflight_pc_q <= '0;
            head_q        <= '0;
            tail_q        <= '0;
            count_q       <= '0;
        end else begin
            state_q       <= state_d;
            rel_q         <= rel_d;
            fetch_pc_q    <= fetch_pc_d;
            inflight_q    <= inflight_d;
            inflight_pc_q <= inflight_pc_d;
            head_q        <= head_d;
            tail_q        <= tail_d;
            count_q       <= count_d;
        end
    end

    // NOTE: queue storage is not reset; count_q alone decides which entries are meaningful.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            q_pc[tail_q]    <= inflight_pc_q;
            q_instr[tail_q] <= imem_data;
        end
    end

    ifq_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(wr_en && !deq && count_q == CW'(DEPTH)));

`ifdef IFQ_STATS_EN
    logic [31:0] stall_q, stall_d;
    logic [15:0] flush_q, flush_d;

    always_comb begin
        stall_d = stall_q;
        flush_d = flush_q;
        if (out_valid && !out_ready && stall_q != '1) begin
            stall_d = stall_q + 32'd1;
        end
        if (jump_valid && flush_q != '1) begin
            flush_d = flush_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            stall_q <= stall_d;
            flush_q <= flush_d;
        end
    end

    assign stat_stall = stall_q;
    assign stat_flush = flush_q;
`endif
endmodule

// File: tb/tb_raisin64_ifetch_queue.sv
// Scoreboard bench for raisin64_ifetch_queue: directed scenarios then randomized ready/jump traffic.
module tb_raisin64_ifetch_queue;
    localparam logic [63:0] RESET_PC = 64'h0;
    localparam int          IMEM_AW  = 16;
    localparam int          DEPTH    = 4;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               imem_en;
    logic [IMEM_AW-1:0] imem_addr;
    logic [63:0]        imem_data = '0;
    logic               jump_valid;
    logic [63:0]        jump_pc;
    logic               out_valid;
    logic [63:0]        out_instr;
    logic [63:0]        out_pc;
    logic               out_ready;
`ifdef IFQ_STATS_EN
    logic [31:0]        stat_stall;
    logic [15:0]        stat_flush;
`endif

    always #5 clk = ~clk;

    raisin64_ifetch_queue #(
        .RESET_PC (RESET_PC),
        .IMEM_AW  (IMEM_AW),
        .DEPTH    (DEPTH)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .imem_en    (imem_en),
        .imem_addr  (imem_addr),
        .imem_data  (imem_data),
        .jump_valid (jump_valid),
        .jump_pc    (jump_pc),
        .out_valid  (out_valid),
        .out_instr  (out_instr),
        .out_pc     (out_pc),
        .out_ready  (out_ready)
`ifdef IFQ_STATS_EN
        ,
        .stat_stall (stat_stall),
        .stat_flush (stat_flush)
`endif
    );

    // Instruction memory: word i holds 0x1000 + i, one-cycle synchronous read.
    always @(posedge clk) begin
        if (imem_en) imem_data <= 64'h1000 + 64'(imem_addr);
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        check(name, 64'(act), 64'(exp));
    endtask

    // Reference: word address is the byte address divided by 8, modulo the imem size.
    function automatic logic [63:0] word_addr(input logic [63:0] pc);
        return (pc >> 3) % (64'd1 << IMEM_AW);
    endfunction

    function automatic logic [63:0] word_at(input logic [63:0] pc);
        return 64'h1000 + word_addr(pc);
    endfunction

    // Reference model state: expected pc stream, redirect tracking, hold tracking.
    logic [63:0] exp_q [$];
    int          rel_cyc    = -1;
    int          jump_age   = 99;
    logic [63:0] jtarget    = '0;
    logic        hold       = 1'b0;
    logic [63:0] hold_pc    = '0;
    logic [63:0] hold_instr = '0;
    logic        stream_chk = 1'b0;
    int          m_stall    = 0;
    int          m_flush    = 0;

    always @(negedge clk) begin
        logic [63:0] e;
        if (!rst_n) begin
            check1("rst_imem_en", imem_en, 1'b0);
            check1("rst_out_valid", out_valid, 1'b0);
            check("rst_out_pc", out_pc, 64'h0);
            check("rst_out_instr", out_instr, 64'h0);
            check("rst_imem_addr", 64'(imem_addr), word_addr(RESET_PC));
`ifdef IFQ_STATS_EN
            check("rst_stat_stall", 64'(stat_stall), 64'h0);
            check("rst_stat_flush", 64'(stat_flush), 64'h0);
`endif
            rel_cyc  = -1;
            jump_age = 99;
            hold     = 1'b0;
            m_stall  = 0;
            m_flush  = 0;
            exp_q.delete();
            exp_q.push_back(RESET_PC & ~64'h7);
        end else begin
            rel_cyc++;
            if (rel_cyc <= 2) check1("fill_no_valid", out_valid, 1'b0);
            if (rel_cyc <= 1) check1("idle_no_fetch", imem_en, 1'b0);
            if (rel_cyc == 2) begin
                check1("first_fetch_en", imem_en, 1'b1);
                check("first_fetch_addr", 64'(imem_addr), word_addr(RESET_PC));
            end
            if (rel_cyc == 3) begin
                check1("fill_valid", out_valid, 1'b1);
                check("fill_pc", out_pc, RESET_PC & ~64'h7);
            end
`ifdef IFQ_STATS_EN
            check("stat_stall", 64'(stat_stall), 64'(m_stall));
            check("stat_flush", 64'(stat_flush), 64'(m_flush));
`endif
            if (hold) begin
                check1("hold_valid", out_valid, 1'b1);
                check("hold_pc", out_pc, hold_pc);
                check("hold_instr", out_instr, hold_instr);
            end
            if (stream_chk && rel_cyc >= 3) check1("stream_no_gap", out_valid, 1'b1);
            if (!jump_valid && jump_age == 0) begin
                check1("jump_refetch_en", imem_en, 1'b1);
                check("jump_refetch_addr", 64'(imem_addr), word_addr(jtarget));
            end
            if (!jump_valid && jump_age == 1) begin
                check1("jump_head_valid", out_valid, 1'b1);
                check("jump_head_pc", out_pc, jtarget);
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check1("pop_unexpected", 1'b1, 1'b0);
                end else begin
                    e = exp_q.pop_front();
                    check("pop_pc", out_pc, e);
                    check("pop_instr", out_instr, word_at(e));
                    if (exp_q.size() == 0) exp_q.push_back(e + 64'd8);
                end
            end
            if (jump_valid) begin
                check1("jump_no_fetch", imem_en, 1'b0);
                jtarget = jump_pc & ~64'h7;
                exp_q.delete();
                exp_q.push_back(jtarget);
                jump_age = (rel_cyc >= 1) ? 0 : 99;
            end else if (jump_age < 99) begin
                jump_age++;
            end
            hold       = out_valid && !out_ready && !jump_valid;
            hold_pc    = out_pc;
            hold_instr = out_instr;
            if (out_valid && !out_ready) m_stall++;
            if (jump_valid) m_flush++;
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: bench did not finish, checks %0d", checks);
        $fatal(1);
    end

    initial begin
        int en_cnt;
        int hold_j;
        int since_rel;
        rst_n      = 1'b0;
        out_ready  = 1'b0;
        jump_valid = 1'b0;
        jump_pc    = '0;
        step(3);

        // Fill latency and back-to-back stream.
        rst_n = 1'b1; out_ready = 1'b1; stream_chk = 1'b1;
        step(12);
        stream_chk = 1'b0;

        // Redirect mid-stream to an unaligned target.
        jump_valid = 1'b1; jump_pc = 64'h40F; step(1);
        jump_valid = 1'b0; step(6);

        // Redirect right after a read issue while decode is stalled.
        out_ready = 1'b0; step(1);
        jump_valid = 1'b1; jump_pc = 64'h2000; step(1);
        jump_valid = 1'b0; step(8);
        out_ready = 1'b1; step(8);

        // Backpressure from reset: exactly DEPTH reads, then an in-order drain with no gaps.
        rst_n = 1'b0; step(2);
        rst_n = 1'b1; out_ready = 1'b0;
        en_cnt = 0;
        repeat (20) begin
            @(negedge clk);
            en_cnt += int'(imem_en);
        end
        check("bp_read_count", 64'(en_cnt), 64'(DEPTH));
        @(posedge clk); #1;
        check("bp_head_pc", out_pc, RESET_PC & ~64'h7);
        out_ready = 1'b1; stream_chk = 1'b1;
        step(10);
        stream_chk = 1'b0;

        // Jump coinciding with a pop, to a target that wraps the 64-bit pc.
        jump_valid = 1'b1; jump_pc = 64'hFFFF_FFFF_FFFF_FFF8; step(1);
        jump_valid = 1'b0; step(6);

        // Backpressure cycles and three jumps, then reset mid-stream.
        out_ready = 1'b0; step(7);
        out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            jump_valid = 1'b1; jump_pc = 64'h100 * (k + 1); step(1);
            jump_valid = 1'b0; step(4);
        end
        rst_n = 1'b0; step(2);
        rst_n = 1'b1; step(5);

        // Randomized ready/jump traffic with one more reset.
        hold_j    = 0;
        since_rel = 5;
        for (int i = 0; i < 1500; i++) begin
            out_ready = ($urandom_range(0, 3) != 0);
            if (i == 700) begin
                rst_n  = 1'b0;
                hold_j = 0;
            end
            if (i == 703) begin
                rst_n     = 1'b1;
                since_rel = 0;
            end
            if (hold_j > 0) begin
                hold_j--;
            end else if (rst_n && since_rel > 4 && $urandom_range(0, 11) == 0) begin
                hold_j  = $urandom_range(1, 3);
                jump_pc = ($urandom_range(0, 3) == 0) ? {32'hFFFF_FFFF, $urandom} : {32'h0, $urandom};
            end
            jump_valid = (hold_j > 0);
            since_rel++;
            step(1);
        end
        jump_valid = 1'b0;
        step(3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
